psum_gb_channel: RTL and testbench

- Global-buffer-side endpoint for one partial-sum channel of the PE array. It is the responder to the PE-side PSUM ports.
- It sources GBPSUM rows (the previous pass's partial sums, or zeros on the first pass) and sinks PSUMGB rows (the updated partial sums).
- Rows are stored in a circular row FIFO between passes. On the final pass, rows are forwarded to an output port toward DRAM/pooling.
- Three instances serve channels 0/1/2.

---
 rtl/psum_gb_channel_if.sv | 12 +
 rtl/psum_gb_channel.sv | 154 +++++++++++++++
 tb/tb_psum_gb_channel.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_gb_channel_if.sv
// Valid/ready row channel between the global buffer and the PE array.
// master drives val/data, slave answers with rdy.
interface psum_gb_channel_if #(
  parameter int W = 368
);
  logic         val;
  logic [W-1:0] data;
  logic         rdy;

  modport master (output val, output data, input rdy);
  modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/psum_gb_channel.sv
// Global-buffer endpoint for one partial-sum channel: sources rows to the PE array,
// parks returned rows in a circular row FIFO between passes, forwards the final pass.
module psum_gb_channel #(
  parameter int PSUM_WIDTH = 23,
  parameter int LENROW     = 16,
  parameter int DEPTH      = 16,
  parameter int PASS_W     = 8,
  localparam int ROW_W     = PSUM_WIDTH * LENROW,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_num_rows,
  input  logic [PASS_W-1:0]    cfg_num_pass,
  psum_gb_channel_if.master    gbpsum,
  psum_gb_channel_if.slave     psumgb,
  psum_gb_channel_if.master    out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_RUN   = 1'b1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [0:0]        state_reg;
  logic [CNT_W-1:0]  num_rows_reg;
  logic [PASS_W-1:0] num_pass_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [CNT_W-1:0]  wr_cnt_reg;
  logic [PASS_W-1:0] pass_cnt_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  occ_reg;
  logic              done_reg;
  logic [ROW_W-1:0]  rd_data_reg;
  logic [ROW_W-1:0]  mem [DEPTH];

  logic             run;
  logic             first_pass;
  logic             final_pass;
  logic             cfg_ok;
  logic             launch;
  logic             gb_val;
  logic             gb_xfer;
  logic             pop;
  logic             ret_ok;
  logic             pg_rdy;
  logic             pg_xfer;
  logic             push;
  logic             out_val;
  logic             pass_end;
  logic [PTR_W-1:0] rd_ptr_next;

  always_comb begin
    run        = (state_reg == S_RUN);
    first_pass = (pass_cnt_reg == '0);
    final_pass = (pass_cnt_reg == num_pass_reg - PASS_W'(1));
    cfg_ok     = (cfg_num_rows != '0) && (cfg_num_rows <= DEPTH_C) && (cfg_num_pass != '0);
    launch     = (state_reg == S_IDLE) && start && cfg_ok;

    gb_val  = run && (rd_cnt_reg < num_rows_reg) && (first_pass || (occ_reg != '0));
    gb_xfer = gb_val && gbpsum.rdy;
    pop     = gb_xfer && !first_pass;

    // A row can only come back after it was issued; rdy uses registered occupancy.
    ret_ok  = run && (wr_cnt_reg < rd_cnt_reg) && (wr_cnt_reg < num_rows_reg);
    pg_rdy  = ret_ok && (final_pass ? out.rdy : (occ_reg < DEPTH_C));
    pg_xfer = psumgb.val && pg_rdy;
    push    = pg_xfer && !final_pass;
    out_val = ret_ok && final_pass && psumgb.val;

    pass_end = run && (rd_cnt_reg == num_rows_reg) && (wr_cnt_reg == num_rows_reg);

    rd_ptr_next = rd_ptr_reg;
    if (launch) begin
      rd_ptr_next = '0;
    end else if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
  end

  assign gbpsum.val  = gb_val;
  assign gbpsum.data = (gb_val && !first_pass) ? rd_data_reg : '0;
  assign psumgb.rdy  = pg_rdy;
  assign out.val     = out_val;
  assign out.data    = out_val ? psumgb.data : '0;
  assign busy        = run;
  assign done        = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      num_rows_reg <= '0;
      num_pass_reg <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      pass_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (launch) begin
        state_reg    <= S_RUN;
        num_rows_reg <= cfg_num_rows;
        num_pass_reg <= cfg_num_pass;
        rd_cnt_reg   <= '0;
        wr_cnt_reg   <= '0;
        pass_cnt_reg <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        occ_reg      <= '0;
      end else if (run) begin
        if (pass_end) begin
          if (final_pass) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end else begin
            pass_cnt_reg <= pass_cnt_reg + PASS_W'(1);
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
          end
        end else begin
          if (gb_xfer) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
          if (pg_xfer) wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
          if (push)    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          rd_ptr_reg <= rd_ptr_next;
          case ({push, pop})
            2'b10:   occ_reg <= occ_reg + CNT_W'(1);
            2'b01:   occ_reg <= occ_reg - CNT_W'(1);
            default: occ_reg <= occ_reg;
          endcase
        end
      end
    end
  end

  // Registered read prefetches the next head; a same-cycle write to that slot is forwarded.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= psumgb.data;
    end
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      rd_data_reg <= psumgb.data;
    end else begin
      rd_data_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: tb/tb_psum_gb_channel.sv
// Scoreboard bench for psum_gb_channel: a PE model returns rows, expected GBPSUM
// and output rows are queued as stimulus is produced and popped on each transfer.
module tb_psum_gb_channel;
  localparam int PW     = 23;
  localparam int LR     = 16;
  localparam int DEPTH  = 16;
  localparam int PASS_W = 8;
  localparam int ROWW   = PW * LR;
  localparam int CW     = $clog2(DEPTH + 1);

  typedef logic [ROWW-1:0] row_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     cfg_num_rows;
  logic [PASS_W-1:0] cfg_num_pass;
  logic              busy;
  logic              done;

  psum_gb_channel_if #(.W(ROWW)) gb_if ();
  psum_gb_channel_if #(.W(ROWW)) pg_if ();
  psum_gb_channel_if #(.W(ROWW)) out_if ();

  psum_gb_channel #(
    .PSUM_WIDTH(PW), .LENROW(LR), .DEPTH(DEPTH), .PASS_W(PASS_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_rows(cfg_num_rows), .cfg_num_pass(cfg_num_pass),
    .gbpsum(gb_if), .psumgb(pg_if), .out(out_if),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input row_t got, input row_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PE / scoreboard model state
  int   nrows, npass, mode, issued, returned, occ_m, done_cnt, out_rows, stall_left;
  bit   gb_rand, stalled_prev, expect_launch;
  bit   prev_gb_wait, prev_out_wait;
  row_t prev_gb_data, prev_out_data;
  row_t pend_q[$];
  row_t exp_gb_q[$];
  row_t exp_out_q[$];

  function automatic row_t rep(input int v);
    row_t r;
    for (int e = 0; e < LR; e++) r[e*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic row_t ret_row(input row_t rx, input int idx);
    row_t r;
    for (int e = 0; e < LR; e++) begin
      case (mode)
        0:       r[e*PW +: PW] = PW'((idx % nrows) + 1);
        1:       r[e*PW +: PW] = rx[e*PW +: PW] + PW'(1);
        default: r[e*PW +: PW] = rx[e*PW +: PW] + PW'(idx * LR + e + 1);
      endcase
    end
    return r;
  endfunction

  // Entered right after a negedge; drives, samples at +1, returns at the next negedge.
  task automatic step();
    row_t e;
    row_t row;
    int   p;
    bit   gx, px, ox;
    gb_if.rdy = gb_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_q.size() > 0) begin
      pg_if.val  = 1'b1;
      pg_if.data = pend_q[0];
    end else begin
      pg_if.val  = 1'b0;
      pg_if.data = '0;
    end
    out_if.rdy = (stall_left == 0);
    #1;
    if (expect_launch) begin
      check("val_after_start", row_t'(gb_if.val), row_t'(1));
      check("busy_after_start", row_t'(busy), row_t'(1));
      expect_launch = 1'b0;
    end
    if (prev_gb_wait) begin
      check("gb_hold_val", row_t'(gb_if.val), row_t'(1));
      check("gb_hold_data", gb_if.data, prev_gb_data);
    end
    if (prev_out_wait) begin
      check("out_hold_val", row_t'(out_if.val), row_t'(1));
      check("out_hold_data", out_if.data, prev_out_data);
    end
    if (pg_if.rdy) begin
      check("rdy_after_issue", row_t'(returned < issued), row_t'(1));
      if (returned / nrows < npass - 1)
        check("no_overflow", row_t'(occ_m < DEPTH), row_t'(1));
    end
    gx = gb_if.val && gb_if.rdy;
    px = pg_if.val && pg_if.rdy;
    ox = out_if.val && out_if.rdy;
    if (gx) begin
      p = issued / nrows;
      e = '0;
      if (p > 0) begin
        if (exp_gb_q.size() == 0) check("gb_q_len", row_t'(exp_gb_q.size()), row_t'(1));
        else e = exp_gb_q.pop_front();
        occ_m--;
      end
      check("gb_data", gb_if.data, e);
      pend_q.push_back(ret_row(e, issued));
      $display("%0t gbpsum row=%0d pass=%0d", $time, issued, p);
      issued++;
    end
    if (px) begin
      p   = returned / nrows;
      row = pend_q.pop_front();
      if (p < npass - 1) begin
        exp_gb_q.push_back(row);
        occ_m++;
      end else begin
        exp_out_q.push_back(row);
      end
      check("out_with_return", row_t'(ox), row_t'(p == npass - 1));
      $display("%0t psumgb row=%0d pass=%0d", $time, returned, p);
      returned++;
    end
    if (ox) begin
      if (exp_out_q.size() == 0) begin
        check("out_q_len", row_t'(exp_out_q.size()), row_t'(1));
      end else begin
        e = exp_out_q.pop_front();
        check("out_data", out_if.data, e);
      end
      if (mode == 1) check("out_is_3", out_if.data, rep(3));
      $display("%0t out row=%0d", $time, out_rows);
      out_rows++;
    end
    if (out_if.val && stall_left > 0) begin
      check("stall_rdy", row_t'(pg_if.rdy), row_t'(0));
      stall_left--;
      stalled_prev = 1'b1;
    end else if (stalled_prev && out_if.rdy) begin
      check("stall_release", row_t'(ox), row_t'(1));
      stalled_prev = 1'b0;
    end
    if (done) begin
      done_cnt++;
      check("done_rows", row_t'(returned), row_t'(nrows * npass));
      check("busy_at_done", row_t'(busy), row_t'(0));
      $display("%0t done", $time);
    end
    prev_gb_wait  = gb_if.val && !gx;
    prev_gb_data  = gb_if.data;
    prev_out_wait = out_if.val && !ox;
    prev_out_data = out_if.data;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, row_t'(busy), row_t'(0));
    check({tag, "_done"}, row_t'(done), row_t'(0));
    check({tag, "_gb_val"}, row_t'(gb_if.val), row_t'(0));
    check({tag, "_gb_data"}, gb_if.data, row_t'(0));
    check({tag, "_pg_rdy"}, row_t'(pg_if.rdy), row_t'(0));
    check({tag, "_out_val"}, row_t'(out_if.val), row_t'(0));
    check({tag, "_out_data"}, out_if.data, row_t'(0));
  endtask

  task automatic run_job(input int rows, input int passes, input int mode_i, input bit rand_i,
                         input int stall_i, input int restart_at, input int abort_at);
    bit fin;
    bit aborted;
    nrows = rows; npass = passes; mode = mode_i; gb_rand = rand_i; stall_left = stall_i;
    issued = 0; returned = 0; occ_m = 0; done_cnt = 0; out_rows = 0;
    stalled_prev = 1'b0; prev_gb_wait = 1'b0; prev_out_wait = 1'b0;
    pend_q.delete(); exp_gb_q.delete(); exp_out_q.delete();
    fin = 1'b0; aborted = 1'b0;
    start = 1'b1; cfg_num_rows = CW'(rows); cfg_num_pass = PASS_W'(passes);
    step();
    start = 1'b0;
    expect_launch = 1'b1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (abort_at > 0 && issued >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (cyc == restart_at) begin
        start = 1'b1; cfg_num_rows = CW'(1); cfg_num_pass = PASS_W'(1);
      end
      step();
      start = 1'b0;
      if (done_cnt > 0) fin = 1'b1;
    end
    if (aborted) begin
      reset = 1'b1; pg_if.val = 1'b0; pg_if.data = '0; gb_if.rdy = 1'b0; out_if.rdy = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("abort");
      @(negedge clk);
      reset = 1'b0;
      pend_q.delete(); exp_gb_q.delete(); exp_out_q.delete();
      prev_gb_wait = 1'b0; prev_out_wait = 1'b0;
      return;
    end
    check("job_finished", row_t'(fin), row_t'(1));
    check("done_once", row_t'(done_cnt), row_t'(1));
    check("done_pulse", row_t'(done), row_t'(0));
    check("out_rows", row_t'(out_rows), row_t'(rows));
    check("queues_empty", row_t'(pend_q.size() + exp_gb_q.size() + exp_out_q.size()), row_t'(0));
    check("fifo_empty", row_t'(occ_m), row_t'(0));
  endtask

  task automatic bad_start(input int rows, input int passes);
    start = 1'b1; cfg_num_rows = CW'(rows); cfg_num_pass = PASS_W'(passes);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("bad_start_busy", row_t'(busy), row_t'(0));
    check("bad_start_gb_val", row_t'(gb_if.val), row_t'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_num_rows = '0; cfg_num_pass = '0;
    gb_if.rdy = 1'b0; pg_if.val = 1'b0; pg_if.data = '0; out_if.rdy = 1'b0;
    expect_launch = 1'b0; prev_gb_wait = 1'b0; prev_out_wait = 1'b0;
    nrows = 1; npass = 1; stall_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_job(4, 1, 0, 1'b0, 0, -1, -1);
    check("single_pass_stored", row_t'(exp_gb_q.size()), row_t'(0));
    run_job(3, 3, 1, 1'b0, 0, -1, -1);
    run_job(DEPTH, 2, 2, 1'b1, 0, -1, -1);
    run_job(2, 2, 2, 1'b0, 5, -1, -1);

    bad_start(0, 1);
    bad_start(DEPTH + 1, 1);
    bad_start(2, 0);
    run_job(3, 2, 2, 1'b1, 0, 4, -1);

    run_job(3, 3, 1, 1'b0, 0, -1, 4);
    run_job(2, 1, 0, 1'b0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
